// File: rtl/fp_pkg.sv
// Shared definitions for the single-precision add/sub datapath: field widths,
// extended-mantissa bit positions and the operand unpack helper.
package fp_pkg;

  localparam int unsigned EXP_W       = 8;
  localparam int unsigned FRAC_W      = 23;
  localparam int unsigned EXT_W       = 28;
  localparam logic [7:0]  EXP_SPECIAL = 8'hFF;
  localparam int unsigned DIFF_MAX    = 28;

  // Width of the remaining-shift counter; holds 0..DIFF_MAX.
  localparam int unsigned REM_W = 5;

  // Extended-mantissa layout, shared with the rounding stage.
  localparam int unsigned EXT_HIDDEN    = 27;
  localparam int unsigned EXT_FRAC_MSB  = 26;
  localparam int unsigned EXT_FRAC_LSB  = 4;
  localparam int unsigned EXT_GUARD_MSB = 3;
  localparam int unsigned EXT_GUARD_LSB = 1;
  localparam int unsigned EXT_STICKY    = 0;

  typedef enum logic [1:0] {
    StIdle,
    StCmp,
    StShift,
    StDone
  } state_e;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [EXT_W-1:0] mant;
  } unpacked_t;

  // Denormals get effective exponent 1 and no hidden bit.
  function automatic unpacked_t unpack(input logic [31:0] x);
    unpacked_t u;
    u.sign = x[31];
    if (x[EXP_W+FRAC_W-1:FRAC_W] != '0) begin
      u.exp  = x[EXP_W+FRAC_W-1:FRAC_W];
      u.mant = {1'b1, x[FRAC_W-1:0], 4'b0000};
    end else begin
      u.exp  = 8'd1;
      u.mant = {1'b0, x[FRAC_W-1:0], 4'b0000};
    end
    return u;
  endfunction

endpackage

// File: rtl/align_shr_step.sv
// Combinational right shift of an extended mantissa by 0..STEP bits. Every bit
// that leaves the word (including the old sticky bit) is ORed into bit 0.
module align_shr_step
  import fp_pkg::*;
#(
  parameter int unsigned STEP = 4,
  localparam int unsigned AMT_W = $clog2(STEP + 1)
) (
  input  logic [EXT_W-1:0] din,
  input  logic [AMT_W-1:0] amt,
  output logic [EXT_W-1:0] dout
);

  logic [EXT_W-1:0] lost_mask;
  logic             lost;

  // Shift and fold the departing bits into sticky
  always_comb begin
    lost_mask        = (EXT_W'(1) << amt) - EXT_W'(1);
    lost             = |(din & lost_mask);
    dout             = din >> amt;
    dout[EXT_STICKY] = dout[EXT_STICKY] | lost;
  end

endmodule

// File: rtl/fp_align.sv
// Pre-normalization stage: unpacks two binary32 operands, orders them by
// magnitude and right-aligns the smaller mantissa to the larger exponent,
// STEP bits per cycle, keeping a sticky bit.
module fp_align
  import fp_pkg::*;
#(
  parameter int unsigned STEP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      a,
  input  logic [31:0]      b,
  input  logic             operator,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [EXP_W-1:0] exp_out,
  output logic [EXT_W-1:0] mantis_big,
  output logic [EXT_W-1:0] mantis_small,
  output logic             sign_big,
  output logic             sign_small,
  output logic             eff_sub,
  output logic             swapped,
  output logic             special
);

  localparam int unsigned     AMT_W      = $clog2(STEP + 1);
  localparam logic [REM_W-1:0] STEP_R     = REM_W'(STEP);
  localparam logic [REM_W-1:0] DIFF_MAX_R = REM_W'(DIFF_MAX);

  state_e state_q, state_d;

  logic [31:0]      a_q, b_q;
  logic             op_q;
  logic [EXP_W-1:0] exp_q;
  logic [EXT_W-1:0] big_q, small_q;
  logic             sign_big_q, sign_small_q, eff_sub_q, swapped_q, special_q;
  logic [REM_W-1:0] rem_q;

  unpacked_t        ua, ub, ubig, usmall;
  logic             b_larger;
  logic [EXP_W-1:0] exp_diff;
  logic [REM_W-1:0] diff_clamped;
  logic             is_special;

  logic [REM_W-1:0] step_k;
  logic [AMT_W-1:0] shift_amt;
  logic [EXT_W-1:0] small_shifted;

  // Operand ordering and exponent difference for the compare cycle
  always_comb begin
    ua       = unpack(a_q);
    ub       = unpack(b_q);
    b_larger = (ub.exp > ua.exp) || ((ub.exp == ua.exp) && (ub.mant > ua.mant));
    ubig     = b_larger ? ub : ua;
    usmall   = b_larger ? ua : ub;
    exp_diff = ubig.exp - usmall.exp;
    diff_clamped = (exp_diff > EXP_W'(DIFF_MAX)) ? DIFF_MAX_R : exp_diff[REM_W-1:0];
    is_special = (a_q[EXP_W+FRAC_W-1:FRAC_W] == EXP_SPECIAL) ||
                 (b_q[EXP_W+FRAC_W-1:FRAC_W] == EXP_SPECIAL);
  end

  // Per-cycle shift amount: min(STEP, remaining)
  always_comb begin
    step_k    = (rem_q > STEP_R) ? STEP_R : rem_q;
    shift_amt = AMT_W'(step_k);
  end

  align_shr_step #(
    .STEP (STEP)
  ) u_shr (
    .din  (small_q),
    .amt  (shift_amt),
    .dout (small_shifted)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (in_valid) state_d = StCmp;
      end
      StCmp: begin
        if (is_special || (diff_clamped == '0)) state_d = StDone;
        else                                    state_d = StShift;
      end
      StShift: begin
        if (rem_q <= STEP_R) state_d = StDone;
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
  end

  // Operand capture, compare load and shift datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= 1'b0;
      exp_q        <= '0;
      big_q        <= '0;
      small_q      <= '0;
      sign_big_q   <= 1'b0;
      sign_small_q <= 1'b0;
      eff_sub_q    <= 1'b0;
      swapped_q    <= 1'b0;
      special_q    <= 1'b0;
      rem_q        <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            a_q  <= a;
            b_q  <= b;
            op_q <= operator;
          end
        end
        StCmp: begin
          exp_q        <= ubig.exp;
          big_q        <= ubig.mant;
          small_q      <= usmall.mant;
          sign_big_q   <= ubig.sign;
          sign_small_q <= usmall.sign;
          eff_sub_q    <= op_q ^ a_q[31] ^ b_q[31];
          swapped_q    <= b_larger;
          special_q    <= is_special;
          // Inf/NaN pass through unshifted
          rem_q        <= is_special ? '0 : diff_clamped;
        end
        StShift: begin
          small_q <= small_shifted;
          rem_q   <= rem_q - step_k;
        end
        default: ;
      endcase
    end
  end

  // Result outputs come straight from registers so they hold under backpressure
  always_comb begin
    exp_out      = exp_q;
    mantis_big   = big_q;
    mantis_small = small_q;
    sign_big     = sign_big_q;
    sign_small   = sign_small_q;
    eff_sub      = eff_sub_q;
    swapped      = swapped_q;
    special      = special_q;
  end

endmodule
